// File: rtl/fifo_rd_unpack.sv
// Reads one wide word from an upstream FIFO and writes it out as RATIO narrow
// slices to a downstream FIFO, in either MSB-first or LSB-first slice order.
module fifo_rd_unpack #(
  parameter int IN_WIDTH  = 256,
  parameter int OUT_WIDTH = 32,
  parameter     ORDER     = "MSB_FIRST"
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 enable,
  output logic                 fifo_b_rden,
  input  logic [IN_WIDTH-1:0]  fifo_b_rddata,
  input  logic                 fifo_b_empty,
  output logic                 fifo_a_wren,
  output logic [OUT_WIDTH-1:0] fifo_a_wrdata,
  input  logic                 fifo_a_full,
  output logic                 busy
);

  localparam int RATIO = IN_WIDTH / OUT_WIDTH;
  localparam int CNT_W = (RATIO > 1) ? $clog2(RATIO) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(RATIO - 1);
  localparam bit LSB_FIRST = (ORDER == "LSB_FIRST");

  generate
    if ((IN_WIDTH % OUT_WIDTH) != 0 || RATIO < 2) begin : g_bad_ratio
      $error("fifo_rd_unpack: IN_WIDTH must be a multiple (>= 2x) of OUT_WIDTH");
    end
    if (ORDER != "MSB_FIRST" && ORDER != "LSB_FIRST") begin : g_bad_order
      $error("fifo_rd_unpack: ORDER must be \"MSB_FIRST\" or \"LSB_FIRST\"");
    end
  endgenerate

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    EMIT = 2'd2
  } state_t;

  state_t                          state;
  logic [RATIO-1:0][OUT_WIDTH-1:0] hold_buf;
  logic [CNT_W-1:0]                cnt;
  logic [CNT_W-1:0]                sel;
  logic                            can_read;
  logic                            last_wr;

  // NOTE: the strobes are combinational so a full/empty change is honoured in
  // the very cycle it happens; rst_n is folded in so no read leaks out during reset.
  always_comb begin
    can_read      = rst_n & enable & ~fifo_b_empty;
    fifo_a_wren   = (state == EMIT) & ~fifo_a_full;
    last_wr       = fifo_a_wren & (cnt == LAST);
    fifo_b_rden   = can_read & ((state == IDLE) | last_wr);
    busy          = (state != IDLE);
    sel           = LSB_FIRST ? cnt : (LAST - cnt);
    fifo_a_wrdata = hold_buf[sel];
  end

  // NOTE: hold_buf is reset (not left undefined) so wrdata reads zero out of reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      cnt      <= '0;
      hold_buf <= '0;
    end else begin
      case (state)
        IDLE: if (fifo_b_rden) state <= WAIT;
        WAIT: begin
          hold_buf <= fifo_b_rddata;
          cnt      <= '0;
          state    <= EMIT;
        end
        EMIT: begin
          if (fifo_a_wren) begin
            if (last_wr) begin
              cnt   <= '0;
              state <= fifo_b_rden ? WAIT : IDLE;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
